// File: rtl/bank_pkg.sv
// Shared types for the bank issue-queue dequeue side: head status encoding and issue payload.
package bank_pkg;

    localparam int PTR_WIDH_DEF     = 6;
    localparam int N_CH_DEF         = 4;
    localparam int CH_W             = 2;
    localparam int CREDIT_WIDTH_DEF = 3;
    localparam int CREDIT_INIT_DEF  = 4;

    typedef enum logic [1:0] {
        HS_IDLE        = 2'd0,
        HS_WAIT_MSHR   = 2'd1,
        HS_WAIT_CREDIT = 2'd2,
        HS_ISSUE       = 2'd3
    } head_state_e;

    typedef struct packed {
        logic [2:0] rob_id;
        logic [1:0] ch_id;
        logic [1:0] opcode;
        logic [6:0] set_way_off;
        logic [7:0] wbuffer_id;
        logic [3:0] cl_state;
    } iss_payload_t;

endpackage

// File: rtl/bank_isu_iq_issue_if.sv
// Valid/ready issue bus from the issue queue head into the bank data pipe.
interface bank_isu_iq_issue_if;

    logic                   valid;
    logic                   ready;
    bank_pkg::iss_payload_t payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/bank_isu_credit_ctr.sv
// One per-channel issue credit counter; a return into an already-full counter is dropped and flagged.
module bank_isu_credit_ctr #(
    parameter int WIDTH = 3,
    parameter int INIT  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dec_i,
    input  logic             rtn_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= WIDTH'(INIT);
            ovf_o <= 1'b0;
        end else begin
            unique case ({dec_i, rtn_i})
                2'b10: cnt_o <= cnt_o - WIDTH'(1);
                2'b01: begin
                    if (cnt_o == WIDTH'(INIT))
                        ovf_o <= 1'b1;
                    else
                        cnt_o <= cnt_o + WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bank_isu_iq_issue.sv
// Issue-queue dequeue end: in-order head issue gated by MSHR linefill, channel credit and output slot.
module bank_isu_iq_issue
    import bank_pkg::*;
#(
    parameter int PTR_WIDH     = PTR_WIDH_DEF,
    parameter int N_CH         = N_CH_DEF,
    parameter int CREDIT_WIDTH = CREDIT_WIDTH_DEF,
    parameter int CREDIT_INIT  = CREDIT_INIT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PTR_WIDH:0]   iq_count_i,
    output logic [PTR_WIDH-1:0] iq_rd_ptr_o,
    input  logic                iq_rd_mshr_allow_i,
    input  logic [2:0]          iq_rd_rob_id_i,
    input  logic [1:0]          iq_rd_ch_id_i,
    input  logic [1:0]          iq_rd_opcode_i,
    input  logic [6:0]          iq_rd_set_way_off_i,
    input  logic [7:0]          iq_rd_wbuffer_id_i,
    input  logic [3:0]          iq_rd_cl_state_i,
    output logic                iq_deq_o,
    input  logic [N_CH-1:0]     credit_rtn_i,
    bank_isu_iq_issue_if.master iss,
    output head_state_e         head_state_o,
    output logic                credit_ovf_o,
    output logic [7:0]          stall_cnt_o
);

    logic [N_CH-1:0][CREDIT_WIDTH-1:0] credit;
    logic [N_CH-1:0]                   ch_dec;
    logic [N_CH-1:0]                   ch_ovf;
    logic                              head_vld;
    logic                              head_credit;
    logic                              out_free;
    logic                              eligible;
    iss_payload_t                      head;
    head_state_e                       hs_nxt;

    assign head = '{
        rob_id:      iq_rd_rob_id_i,
        ch_id:       iq_rd_ch_id_i,
        opcode:      iq_rd_opcode_i,
        set_way_off: iq_rd_set_way_off_i,
        wbuffer_id:  iq_rd_wbuffer_id_i,
        cl_state:    iq_rd_cl_state_i
    };

    assign head_vld    = iq_count_i != '0;
    assign head_credit = credit[iq_rd_ch_id_i] != '0;
    assign out_free    = !iss.valid || iss.ready;
    assign eligible    = head_vld && iq_rd_mshr_allow_i && head_credit && out_free;
    // A reset cycle must not pop: the enqueue side would lose an entry the output never keeps.
    assign iq_deq_o    = eligible && !rst_i;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_dec[c] = iq_deq_o && (iq_rd_ch_id_i == CH_W'(c));

        bank_isu_credit_ctr #(
            .WIDTH (CREDIT_WIDTH),
            .INIT  (CREDIT_INIT)
        ) u_ctr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .dec_i (ch_dec[c]),
            .rtn_i (credit_rtn_i[c]),
            .cnt_o (credit[c]),
            .ovf_o (ch_ovf[c])
        );
    end

    assign credit_ovf_o = |ch_ovf;

    // MSHR outranks credit so a head waiting on both reports the linefill.
    always_comb begin
        hs_nxt = HS_ISSUE;
        if (!head_vld)
            hs_nxt = HS_IDLE;
        else if (!iq_rd_mshr_allow_i)
            hs_nxt = HS_WAIT_MSHR;
        else if (!head_credit)
            hs_nxt = HS_WAIT_CREDIT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iq_rd_ptr_o  <= '0;
            iss.valid    <= 1'b0;
            iss.payload  <= '0;
            head_state_o <= HS_IDLE;
            stall_cnt_o  <= '0;
        end else begin
            if (eligible) begin
                iq_rd_ptr_o <= iq_rd_ptr_o + PTR_WIDH'(1);
                iss.valid   <= 1'b1;
                iss.payload <= head;
            end else if (iss.ready) begin
                iss.valid   <= 1'b0;
            end
            head_state_o <= hs_nxt;
            if (head_vld && !eligible && stall_cnt_o != 8'hFF)
                stall_cnt_o <= stall_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_bank_isu_iq_issue.sv
// Bench for the issue-queue dequeue end: queue-storage model, in-order payload scoreboard, directed scenarios.
module tb_bank_isu_iq_issue;
    import bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  count;
    logic [5:0]  rd_ptr;
    logic        mshr;
    logic        deq;
    logic [3:0]  rtn;
    head_state_e hs;
    logic        ovf;
    logic [7:0]  stall;

    iss_payload_t mem [64];
    iss_payload_t exp_q [$];
    logic [5:0]   wr_ptr;
    logic         deq_seen;
    int           n_chk = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    bank_isu_iq_issue_if iss_if ();

    bank_isu_iq_issue dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .iq_count_i          (count),
        .iq_rd_ptr_o         (rd_ptr),
        .iq_rd_mshr_allow_i  (mshr),
        .iq_rd_rob_id_i      (mem[rd_ptr].rob_id),
        .iq_rd_ch_id_i       (mem[rd_ptr].ch_id),
        .iq_rd_opcode_i      (mem[rd_ptr].opcode),
        .iq_rd_set_way_off_i (mem[rd_ptr].set_way_off),
        .iq_rd_wbuffer_id_i  (mem[rd_ptr].wbuffer_id),
        .iq_rd_cl_state_i    (mem[rd_ptr].cl_state),
        .iq_deq_o            (deq),
        .credit_rtn_i        (rtn),
        .iss                 (iss_if),
        .head_state_o        (hs),
        .credit_ovf_o        (ovf),
        .stall_cnt_o         (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Enqueue one entry into the modelled queue storage and the expected issue order.
    task automatic push(input logic [1:0] ch);
        iss_payload_t p;
        logic [31:0]  r;
        r = $urandom;
        p = r[$bits(iss_payload_t)-1:0];
        p.ch_id = ch;
        mem[wr_ptr] = p;
        wr_ptr = wr_ptr + 6'd1;
        count = count + 7'd1;
        exp_q.push_back(p);
    endtask

    // One clock: sample at the falling edge, score accepted issues, retire popped entries.
    task automatic cyc();
        iss_payload_t e;
        @(negedge clk);
        deq_seen = deq;
        if (iss_if.valid && iss_if.ready) begin
            if (exp_q.size() == 0)
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                check("sb_payload", 32'(iss_if.payload), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (deq_seen) count = count - 7'd1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(iss_if.valid), 32'd0);
        check({tag, "_ptr"},   32'(rd_ptr), 32'd0);
        check({tag, "_hs"},    32'(hs), 32'(HS_IDLE));
        check({tag, "_ovf"},   32'(ovf), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        for (int c = 0; c < 4; c++)
            check({tag, "_credit"}, 32'(dut.credit[c]), 32'd4);
    endtask

    initial begin
        int n;
        rst = 1'b1; count = '0; mshr = 1'b0; rtn = '0; wr_ptr = '0;
        iss_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;

        // Single ch2 entry issues the first cycle, appears registered the next
        mshr = 1'b1;
        push(2'd2);
        cyc();
        check("t1_deq", 32'(deq_seen), 32'd1);
        check("t1_valid", 32'(iss_if.valid), 32'd1);
        check("t1_ptr", 32'(rd_ptr), 32'd1);
        check("t1_credit2", 32'(dut.credit[2]), 32'd3);
        cyc();
        check("t1_nodeq", 32'(deq_seen), 32'd0);
        check("t1_drop", 32'(iss_if.valid), 32'd0);

        // Linefill pending for 5 cycles
        mshr = 1'b0;
        push(2'd2);
        repeat (5) begin
            cyc();
            check("t2_nodeq", 32'(deq_seen), 32'd0);
        end
        check("t2_hs", 32'(hs), 32'(HS_WAIT_MSHR));
        check("t2_stall", 32'(stall), 32'd5);
        mshr = 1'b1;
        cyc();
        check("t2_deq", 32'(deq_seen), 32'd1);
        check("t2_hs_iss", 32'(hs), 32'(HS_ISSUE));
        cyc();

        // Credit exhaustion on ch0
        repeat (5) push(2'd0);
        n = 0;
        repeat (5) begin
            cyc();
            n += int'(deq_seen);
        end
        check("t3_ndeq", 32'(n), 32'd4);
        check("t3_hs", 32'(hs), 32'(HS_WAIT_CREDIT));
        check("t3_credit0", 32'(dut.credit[0]), 32'd0);
        rtn = 4'b0001;
        cyc();
        check("t3_rtn_nodeq", 32'(deq_seen), 32'd0);
        rtn = '0;
        cyc();
        check("t3_deq", 32'(deq_seen), 32'd1);
        cyc();

        // Backpressure: output held stable, then accept-and-reload
        iss_if.ready = 1'b0;
        repeat (3) push(2'd1);
        cyc();
        check("t4_deq", 32'(deq_seen), 32'd1);
        repeat (3) begin
            cyc();
            check("t4_hold_nodeq", 32'(deq_seen), 32'd0);
            check("t4_hold_valid", 32'(iss_if.valid), 32'd1);
            check("t4_hold_payload", 32'(iss_if.payload), 32'(exp_q[0]));
        end
        iss_if.ready = 1'b1;
        cyc();
        check("t4_reload_deq", 32'(deq_seen), 32'd1);
        check("t4_reload_valid", 32'(iss_if.valid), 32'd1);
        cyc();
        check("t4_deq3", 32'(deq_seen), 32'd1);
        cyc();
        check("t4_end_valid", 32'(iss_if.valid), 32'd0);
        check("t4_credit1", 32'(dut.credit[1]), 32'd1);

        // Walk the pointer to 63 on ch2 with matched returns, then wrap
        n = 63 - int'(wr_ptr);
        repeat (n) push(2'd2);
        for (int i = 0; i < 200 && count != 0; i++) begin
            rtn = 4'b0100;
            cyc();
        end
        rtn = '0;
        check("t5_ptr63", 32'(rd_ptr), 32'd63);
        check("t5_credit2", 32'(dut.credit[2]), 32'd2);
        push(2'd1);
        rtn = 4'b0010;
        cyc();
        check("t5_wrap_deq", 32'(deq_seen), 32'd1);
        check("t5_wrap_ptr", 32'(rd_ptr), 32'd0);
        check("t5_decrtn", 32'(dut.credit[1]), 32'd1);
        check("t5_ovf_pre", 32'(ovf), 32'd0);
        rtn = 4'b1000;
        cyc();
        check("t5_ovf", 32'(ovf), 32'd1);
        check("t5_credit3", 32'(dut.credit[3]), 32'd4);
        rtn = 4'b0010;
        cyc();
        check("t5_rtn_inc", 32'(dut.credit[1]), 32'd2);
        check("t5_ovf_sticky", 32'(ovf), 32'd1);
        rtn = '0;

        // Stall counter saturation
        mshr = 1'b0;
        push(2'd0);
        repeat (300) cyc();
        check("sat_stall", 32'(stall), 32'd255);
        check("sat_hs", 32'(hs), 32'(HS_WAIT_MSHR));

        // Reset while an issue is held under backpressure
        rtn = 4'b0001;
        cyc();
        rtn = '0;
        check("t6_credit0", 32'(dut.credit[0]), 32'd1);
        mshr = 1'b1;
        iss_if.ready = 1'b0;
        cyc();
        check("t6_deq", 32'(deq_seen), 32'd1);
        cyc();
        check("t6_held", 32'(iss_if.valid), 32'd1);
        check("t6_ptr_pre", 32'(rd_ptr), 32'd1);
        rst = 1'b1;
        count = '0;
        wr_ptr = '0;
        cyc();
        check_reset_state("t6");
        exp_q.delete();
        rst = 1'b0;
        iss_if.ready = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
